parking_zone_indicator: RTL and testbench



---
 rtl/parking_zone_indicator_pkg.sv | 31 +++
 rtl/parking_zone_indicator_dwell_fsm.sv | 83 ++++++++
 rtl/parking_zone_indicator.sv | 89 ++++++++
 tb/tb_parking_zone_indicator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_zone_indicator_pkg.sv
// Shared zone-state encodings and LED-pair mapping for the parking zone indicator.
package parking_zone_indicator_pkg;

    typedef enum logic [1:0] {
        ST_FREE = 2'b00,
        ST_LOW  = 2'b01,
        ST_FULL = 2'b10
    } zone_state_e;

    typedef struct packed {
        logic green;
        logic red;
    } led_pair_t;

    localparam led_pair_t LED_DARK  = '{green: 1'b0, red: 1'b0};
    localparam led_pair_t LED_BOTH  = '{green: 1'b1, red: 1'b1};
    localparam led_pair_t LED_GREEN = '{green: 1'b1, red: 1'b0};
    localparam led_pair_t LED_RED   = '{green: 1'b0, red: 1'b1};

    // LED pair for an enabled zone; LOW blinks green with the shared phase.
    function automatic led_pair_t led_map(input zone_state_e st, input logic blink_phase);
        led_pair_t pair;
        case (st)
            ST_FREE: pair = LED_GREEN;
            ST_LOW:  pair = '{green: blink_phase, red: 1'b0};
            default: pair = LED_RED;
        endcase
        return pair;
    endfunction

endpackage

// File: rtl/parking_zone_indicator_dwell_fsm.sv
// Per-zone count register, classifier and dwell (anti-flicker) filter with committed state.
module zone_dwell_fsm
    import parking_zone_indicator_pkg::*;
#(
    parameter int unsigned COUNT_W     = 5,
    parameter int unsigned LOW_THRESH  = 2,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COUNT_W-1:0] slots,
    output zone_state_e        state,
    output logic               state_chg
);

    localparam int unsigned     DWELL_W = $clog2(HOLD_CYCLES + 1);
    localparam longint unsigned CNT_MAX = (64'd1 << COUNT_W) - 64'd1;
    // Thresholds beyond the count range saturate, so every non-zero count is LOW.
    localparam logic [COUNT_W-1:0] THRESH =
        (64'(LOW_THRESH) > CNT_MAX) ? COUNT_W'(CNT_MAX) : COUNT_W'(LOW_THRESH);

    logic [COUNT_W-1:0] count_q;
    zone_state_e        state_q,   state_d;
    zone_state_e        pending_q, pending_d;
    logic [DWELL_W-1:0] dwell_q,   dwell_d;
    logic [DWELL_W-1:0] dwell_inc;
    logic               chg_q,     chg_d;
    zone_state_e        cand;

    always_comb begin : classify
        if (count_q == '0) begin
            cand = ST_FULL;
        end else if (count_q <= THRESH) begin
            cand = ST_LOW;
        end else begin
            cand = ST_FREE;
        end
    end

    // A candidate must differ from the committed state for HOLD_CYCLES consecutive cycles.
    always_comb begin : dwell_next
        state_d   = state_q;
        pending_d = pending_q;
        dwell_d   = dwell_q;
        chg_d     = 1'b0;
        dwell_inc = dwell_q + DWELL_W'(1);
        if (cand == state_q) begin
            dwell_d = '0;
        end else begin
            if (cand != pending_q) begin
                pending_d = cand;
                dwell_inc = DWELL_W'(1);
            end
            if (dwell_inc == DWELL_W'(HOLD_CYCLES)) begin
                state_d = cand;
                dwell_d = '0;
                chg_d   = 1'b1;
            end else begin
                dwell_d = dwell_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            count_q   <= '0;
            state_q   <= ST_FULL;
            pending_q <= ST_FREE;
            dwell_q   <= '0;
            chg_q     <= 1'b0;
        end else begin
            count_q   <= slots;
            state_q   <= state_d;
            pending_q <= pending_d;
            dwell_q   <= dwell_d;
            chg_q     <= chg_d;
        end
    end

    assign state     = state_q;
    assign state_chg = chg_q;

endmodule

// File: rtl/parking_zone_indicator.sv
// Multi-zone parking indicator: per-zone dwell filters, shared blink prescaler, registered LED mux.
module parking_zone_indicator
    import parking_zone_indicator_pkg::*;
#(
    parameter int unsigned NUM_ZONES   = 2,
    parameter int unsigned COUNT_W     = 5,
    parameter int unsigned LOW_THRESH  = 2,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_ZONES*COUNT_W-1:0] slots_avail,
    input  logic [NUM_ZONES-1:0]         zone_en,
    input  logic                         lamp_test,
    output logic [NUM_ZONES-1:0]         led_green,
    output logic [NUM_ZONES-1:0]         led_red,
    output logic [2*NUM_ZONES-1:0]       zone_state,
    output logic [NUM_ZONES-1:0]         state_chg
);

    localparam int unsigned PRESC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PRESC_W-1:0]   presc_q;
    logic                 blink_phase;
    logic                 presc_wrap_c;
    zone_state_e          zone_st [NUM_ZONES];
    logic [NUM_ZONES-1:0] led_green_d;
    logic [NUM_ZONES-1:0] led_red_d;
    led_pair_t            pair;

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        zone_dwell_fsm #(
            .COUNT_W     (COUNT_W),
            .LOW_THRESH  (LOW_THRESH),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_dwell (
            .clk       (clk),
            .rst_n     (rst_n),
            .slots     (slots_avail[z*COUNT_W +: COUNT_W]),
            .state     (zone_st[z]),
            .state_chg (state_chg[z])
        );
        assign zone_state[2*z +: 2] = zone_st[z];
    end

    assign presc_wrap_c = (presc_q == PRESC_W'(BLINK_DIV - 1));

    // Free-running blink timebase shared by all zones.
    always_ff @(posedge clk or negedge rst_n) begin : blink_prescaler
        if (!rst_n) begin
            presc_q     <= '0;
            blink_phase <= 1'b0;
        end else if (presc_wrap_c) begin
            presc_q     <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            presc_q     <= presc_q + PRESC_W'(1);
        end
    end

    always_comb begin : led_next
        led_green_d = '0;
        led_red_d   = '0;
        pair        = LED_DARK;
        for (int z = 0; z < NUM_ZONES; z++) begin
            if (lamp_test) begin
                pair = LED_BOTH;
            end else if (zone_en[z]) begin
                pair = led_map(zone_st[z], blink_phase);
            end else begin
                pair = LED_DARK;
            end
            led_green_d[z] = pair.green;
            led_red_d[z]   = pair.red;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : led_regs
        if (!rst_n) begin
            led_green <= '0;
            led_red   <= '1;
        end else begin
            led_green <= led_green_d;
            led_red   <= led_red_d;
        end
    end

endmodule

// File: tb/tb_parking_zone_indicator.sv
// Randomised and directed bench for parking_zone_indicator against a run-length behavioural model.
module tb_parking_zone_indicator;

    localparam int NZ = 2;
    localparam int CW = 5;
    localparam int LT = 2;
    localparam int HC = 4;
    localparam int BD = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NZ*CW-1:0] slots_avail = '0;
    logic [NZ-1:0]   zone_en = '1;
    logic            lamp_test = 1'b0;
    logic [NZ-1:0]   led_green;
    logic [NZ-1:0]   led_red;
    logic [2*NZ-1:0] zone_state;
    logic [NZ-1:0]   state_chg;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;
    bit seen_low0, seen_chg0;

    parking_zone_indicator #(
        .NUM_ZONES(NZ), .COUNT_W(CW), .LOW_THRESH(LT), .HOLD_CYCLES(HC), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .slots_avail(slots_avail), .zone_en(zone_en),
        .lamp_test(lamp_test), .led_green(led_green), .led_red(led_red),
        .zone_state(zone_state), .state_chg(state_chg)
    );

    always #5 clk = ~clk;

    // Model: class 0 FREE, 1 LOW, 2 FULL; a commit happens after HC consecutive identical non-state classes.
    int              m_cnt [NZ];
    int              m_st [NZ];
    int              m_run_cls [NZ];
    int              m_run_len [NZ];
    logic [NZ-1:0]   m_g, m_r, m_chg;
    logic [2*NZ-1:0] m_zs;
    int              m_presc;
    bit              m_phase;

    function automatic int cls(input int c);
        if (c == 0) return 2;
        if (c <= LT) return 1;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int z = 0; z < NZ; z++) begin
                m_cnt[z] = 0; m_st[z] = 2; m_run_cls[z] = 0; m_run_len[z] = 0;
            end
            m_g = '0; m_r = '1; m_chg = '0; m_presc = 0; m_phase = 0;
        end else begin
            for (int z = 0; z < NZ; z++) begin
                int cand;
                if (lamp_test)        begin m_g[z] = 1'b1; m_r[z] = 1'b1; end
                else if (!zone_en[z]) begin m_g[z] = 1'b0; m_r[z] = 1'b0; end
                else if (m_st[z] == 0) begin m_g[z] = 1'b1; m_r[z] = 1'b0; end
                else if (m_st[z] == 1) begin m_g[z] = m_phase; m_r[z] = 1'b0; end
                else                  begin m_g[z] = 1'b0; m_r[z] = 1'b1; end
                cand = cls(m_cnt[z]);
                m_chg[z] = 1'b0;
                if (cand == m_st[z]) begin
                    m_run_len[z] = 0;
                end else begin
                    if (m_run_len[z] > 0 && cand == m_run_cls[z]) m_run_len[z]++;
                    else begin m_run_cls[z] = cand; m_run_len[z] = 1; end
                    if (m_run_len[z] == HC) begin
                        m_st[z] = cand; m_run_len[z] = 0; m_chg[z] = 1'b1;
                    end
                end
                m_cnt[z] = int'(slots_avail[z*CW +: CW]);
            end
            if (m_presc == BD - 1) begin m_presc = 0; m_phase = ~m_phase; end
            else m_presc++;
        end
        for (int z = 0; z < NZ; z++) m_zs[2*z +: 2] = 2'(m_st[z]);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model led_green",  32'(led_green),  32'(m_g));
            check("model led_red",    32'(led_red),    32'(m_r));
            check("model zone_state", 32'(zone_state), 32'(m_zs));
            check("model state_chg",  32'(state_chg),  32'(m_chg));
        end
    end

    task automatic set_zone(input int z, input int v);
        slots_avail[z*CW +: CW] = CW'(v);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            if (zone_state[1:0] == 2'b01) seen_low0 = 1;
            if (state_chg[0]) seen_chg0 = 1;
        end
    endtask

    int toggles;
    logic prev_g1;

    initial begin
        slots_avail = 10'h2a5;
        @(posedge clk);
        #1 chk_en = 1;
        run(2);
        check("reset led_red",    32'(led_red),    32'h3);
        check("reset led_green",  32'(led_green),  32'h0);
        check("reset zone_state", 32'(zone_state), 32'ha);
        check("reset state_chg",  32'(state_chg),  32'h0);

        // First commit after reset
        set_zone(0, 10); set_zone(1, 0); rst_n = 1'b1;
        run(4);
        check("first pre-commit state", 32'(zone_state[1:0]), 32'h2);
        run(1);
        check("first commit state", 32'(zone_state[1:0]), 32'h0);
        check("first commit chg",   32'(state_chg),       32'h1);
        run(1);
        check("first led_green", 32'(led_green), 32'h1);
        check("first led_red",   32'(led_red),   32'h2);
        check("first chg drop",  32'(state_chg), 32'h0);

        // Anti-flicker
        seen_chg0 = 0;
        set_zone(0, 0); run(3); set_zone(0, 10); run(8);
        check("glitch no chg",   32'(seen_chg0),        32'h0);
        check("glitch state",    32'(zone_state[1:0]),  32'h0);
        check("glitch green",    32'(led_green[0]),     32'h1);
        set_zone(0, 0); run(6);
        check("full chg",   32'(seen_chg0),       32'h1);
        check("full state", 32'(zone_state[1:0]), 32'h2);
        check("full red",   32'(led_red[0]),      32'h1);

        // LOW blink on zone1
        set_zone(1, 2); run(6);
        check("low state", 32'(zone_state[3:2]), 32'h1);
        check("low red",   32'(led_red[1]),      32'h0);
        toggles = 0; prev_g1 = led_green[1];
        repeat (32) begin
            @(negedge clk);
            if (led_green[1] != prev_g1) toggles++;
            prev_g1 = led_green[1];
        end
        check("blink toggles", 32'(toggles), 32'd4);
        set_zone(1, 3); run(6);
        check("free1 state", 32'(zone_state[3:2]), 32'h0);
        run(10);
        check("free1 green steady", 32'(led_green[1]), 32'h1);

        // Alternating candidates on zone0
        set_zone(0, 10); run(6);
        seen_low0 = 0; seen_chg0 = 0;
        set_zone(0, 1); run(1); set_zone(0, 1); run(1); set_zone(0, 0); run(7);
        check("alt never low", 32'(seen_low0),       32'h0);
        check("alt chg",       32'(seen_chg0),       32'h1);
        check("alt full",      32'(zone_state[1:0]), 32'h2);

        // Overrides
        lamp_test = 1'b1; run(1);
        check("lamp green", 32'(led_green), 32'h3);
        check("lamp red",   32'(led_red),   32'h3);
        seen_chg0 = 0; set_zone(0, 10); run(6);
        check("lamp chg underneath", 32'(seen_chg0),       32'h1);
        check("lamp state",          32'(zone_state[1:0]), 32'h0);
        check("lamp still red",      32'(led_red),         32'h3);
        lamp_test = 1'b0; zone_en = 2'b01; set_zone(1, 0); run(6);
        check("dark green1", 32'(led_green[1]),    32'h0);
        check("dark red1",   32'(led_red[1]),      32'h0);
        check("dark state1", 32'(zone_state[3:2]), 32'h2);
        check("en green0",   32'(led_green[0]),    32'h1);

        // Async reset mid-dwell
        zone_en = 2'b11; set_zone(1, 3);
        run(6);
        set_zone(0, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async led_red",    32'(led_red),    32'h3);
        check("async led_green",  32'(led_green),  32'h0);
        check("async zone_state", 32'(zone_state), 32'ha);
        check("async state_chg",  32'(state_chg),  32'h0);
        @(negedge clk);
        set_zone(0, 10); rst_n = 1'b1;
        run(4);
        check("post-reset no early commit", 32'(zone_state), 32'ha);
        run(1);
        check("post-reset commit", 32'(zone_state), 32'h0);
        check("simultaneous chg",  32'(state_chg),  32'h3);

        // Randomised phase
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            for (int z = 0; z < NZ; z++) begin
                if ($urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 5))
                        0: set_zone(z, 0);
                        1: set_zone(z, 1);
                        2: set_zone(z, 2);
                        3: set_zone(z, 3);
                        default: set_zone(z, int'($urandom_range(0, 31)));
                    endcase
                end
            end
            if ($urandom_range(0, 39) == 0) zone_en = NZ'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) lamp_test = ~lamp_test;
            if ($urandom_range(0, 299) == 0) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
